// File: rtl/bsg_cgol_pkg.sv
// Shared types and sizing helpers for the CGOL input deserializer and output serializer.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eHDR  = 2'd0,
    eDATA = 2'd1,
    eFULL = 2'd2
  } deser_state_e;

  // Width of a counter or index for x values; never below one bit.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Number of words needed to carry a board of the given bit count.
  function automatic int words_calc(input int bits, input int word_width);
    return (bits + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/bsg_cgol_word_slot_writer.sv
// Board image register: writes one input word into the selected slot; the last
// slot keeps only the bits that land inside the board.
module bsg_cgol_word_slot_writer #(
  parameter int board_bits_p = 1024,
  parameter int word_width_p = 32,
  parameter int cnt_width_p  = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    w_v_i,
  input  logic [cnt_width_p-1:0]  slot_i,
  input  logic [word_width_p-1:0] data_i,
  output logic [board_bits_p-1:0] data_o
);

  logic [board_bits_p-1:0] board_r, board_n;

  // Per-bit enable: bits past the board never exist, so no out-of-range write.
  always_comb begin
    board_n = board_r;
    for (int b = 0; b < board_bits_p; b++) begin
      if (w_v_i && (slot_i == cnt_width_p'(b / word_width_p))) begin
        board_n[b] = data_i[b % word_width_p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) board_r <= '0;
    else           board_r <= board_n;
  end

  assign data_o = board_r;

endmodule

// File: rtl/bsg_cgol_input_deser.sv
// Word-serial to board deserializer: header word (frame count) then board words,
// presented as one board + frame count on a valid/ready output channel.
module bsg_cgol_input_deser
  import bsg_cgol_pkg::*;
#(
  parameter  int board_width_p     = 32,
  parameter  int max_game_length_p = 1024,
  parameter  int word_width_p      = 32,
  localparam int board_bits_lp     = board_width_p * board_width_p,
  localparam int words_lp          = words_calc(board_bits_lp, word_width_p),
  localparam int cnt_width_lp      = safe_clog2(words_lp),
  localparam int game_len_width_lp = safe_clog2(max_game_length_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         en_i,
  input  logic [word_width_p-1:0]      data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [board_bits_lp-1:0]     data_o,
  output logic [game_len_width_lp-1:0] frames_o,
  output logic                         v_o,
  input  logic                         ready_i,
  output deser_state_e                 state_o
);

  // Valid/ready: a transfer happens on any cycle where valid and ready are both
  // high; ready_o and v_o depend only on the registered state.

  wire unused_en = en_i;

  deser_state_e                 state_r, state_n;
  logic [cnt_width_lp-1:0]      cnt_r, cnt_n;
  logic [game_len_width_lp-1:0] frames_r, frames_n;
  logic [game_len_width_lp-1:0] hdr;
  logic [game_len_width_lp-1:0] hdr_sat;
  logic                         wr_v;

  assign hdr     = data_i[game_len_width_lp-1:0];
  assign hdr_sat = (hdr > game_len_width_lp'(max_game_length_p))
                 ? game_len_width_lp'(max_game_length_p) : hdr;

  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    frames_n = frames_r;
    ready_o  = 1'b0;
    v_o      = 1'b0;
    wr_v     = 1'b0;
    unique case (state_r)
      eHDR: begin
        ready_o = 1'b1;
        if (v_i) begin
          frames_n = hdr_sat;
          cnt_n    = '0;
          state_n  = eDATA;
        end
      end
      eDATA: begin
        ready_o = 1'b1;
        if (v_i) begin
          wr_v = 1'b1;
          if (cnt_r == cnt_width_lp'(words_lp - 1)) state_n = eFULL;
          else                                      cnt_n   = cnt_r + cnt_width_lp'(1);
        end
      end
      eFULL: begin
        v_o = 1'b1;
        if (ready_i) begin
          state_n = eHDR;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = eHDR;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r  <= eHDR;
      cnt_r    <= '0;
      frames_r <= '0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      frames_r <= frames_n;
    end
  end

  bsg_cgol_word_slot_writer #(
    .board_bits_p (board_bits_lp),
    .word_width_p (word_width_p),
    .cnt_width_p  (cnt_width_lp)
  ) slot_writer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .w_v_i    (wr_v),
    .slot_i   (cnt_r),
    .data_i   (data_i),
    .data_o   (data_o)
  );

  assign frames_o = frames_r;
  assign state_o  = state_r;

endmodule

// File: tb/tb_bsg_cgol_input_deser.sv
// Directed bench for the input deserializer: a 32x32/32-bit instance and a
// 5x5/8-bit instance exercising last-word masking.
module tb_bsg_cgol_input_deser;
  import bsg_cgol_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance a: 32x32 board, 32-bit words, max 1024 frames
  logic [31:0]   a_data;
  logic          a_v, a_ready, a_v_o, a_ready_i;
  logic [1023:0] a_board;
  logic [10:0]   a_frames;
  deser_state_e  a_state;

  // instance b: 5x5 board, 8-bit words, max 255 frames
  logic [7:0]    b_data;
  logic          b_v, b_ready, b_v_o, b_ready_i;
  logic [24:0]   b_board;
  logic [7:0]    b_frames;
  deser_state_e  b_state;

  bsg_cgol_input_deser #(
    .board_width_p(32), .max_game_length_p(1024), .word_width_p(32)
  ) dut_a (
    .clk_i(clk), .reset_ni(rst_n), .en_i(1'b1),
    .data_i(a_data), .v_i(a_v), .ready_o(a_ready),
    .data_o(a_board), .frames_o(a_frames), .v_o(a_v_o),
    .ready_i(a_ready_i), .state_o(a_state)
  );

  bsg_cgol_input_deser #(
    .board_width_p(5), .max_game_length_p(255), .word_width_p(8)
  ) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .en_i(1'b1),
    .data_i(b_data), .v_i(b_v), .ready_o(b_ready),
    .data_o(b_board), .frames_o(b_frames), .v_o(b_v_o),
    .ready_i(b_ready_i), .state_o(b_state)
  );

  // scoreboard counters
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_a(input logic [31:0] w, input bit gaps);
    int n;
    if (gaps) begin
      n = 0;
      while ($urandom_range(0, 1) == 1 && n < 8) begin
        a_v = 1'b0;
        tick();
        n++;
      end
    end
    a_v = 1'b1;
    a_data = w;
    n = 0;
    while (!a_ready && n < 50) begin
      tick();
      n++;
    end
    chk("a_ready_wait", 64'(a_ready), 64'(1));
    tick();
    a_v = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] w);
    int n;
    b_v = 1'b1;
    b_data = w;
    n = 0;
    while (!b_ready && n < 50) begin
      tick();
      n++;
    end
    chk("b_ready_wait", 64'(b_ready), 64'(1));
    tick();
    b_v = 1'b0;
  endtask

  // 32 board words base|k; v_o must stay low until the last one is taken
  task automatic send_board_a(input logic [31:0] base, input bit gaps);
    for (int k = 0; k < 31; k++) send_a(base | 32'(k), gaps);
    chk("a_v_before_last", 64'(a_v_o), 64'(0));
    send_a(base | 32'd31, gaps);
    chk("a_v_after_last", 64'(a_v_o), 64'(1));
    chk("a_state_full", 64'(a_state), 64'(eFULL));
  endtask

  task automatic check_board_a(input logic [31:0] base);
    for (int k = 0; k < 32; k++)
      chk($sformatf("a_word%0d", k), 64'(a_board[k*32 +: 32]), 64'(base | 32'(k)));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_v = 1'b0; a_data = '0; a_ready_i = 1'b1;
    b_v = 1'b0; b_data = '0; b_ready_i = 1'b1;

    // reset state
    #12;
    chk("rst_a_v", 64'(a_v_o), 64'(0));
    chk("rst_a_ready", 64'(a_ready), 64'(1));
    chk("rst_a_frames", 64'(a_frames), 64'(0));
    chk("rst_a_state", 64'(a_state), 64'(eHDR));
    chk("rst_a_board_lo", a_board[63:0], 64'(0));
    chk("rst_b_board", 64'(b_board), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // packet 1: header 5, gapless
    send_a(32'd5, 1'b0);
    chk("p1_state_data", 64'(a_state), 64'(eDATA));
    send_board_a(32'hA5A5_0000, 1'b0);
    chk("p1_frames", 64'(a_frames), 64'(5));
    check_board_a(32'hA5A5_0000);
    tick();
    chk("p1_ready_after_hs", 64'(a_ready), 64'(1));
    chk("p1_v_after_hs", 64'(a_v_o), 64'(0));

    // packet 2: saturated header
    send_a(32'h0000_FFFF, 1'b0);
    send_board_a(32'h1234_0000, 1'b0);
    chk("p2_frames_sat", 64'(a_frames), 64'(1024));
    check_board_a(32'h1234_0000);
    tick();

    // packet 3: header 7 with 20 cycles of backpressure
    a_ready_i = 1'b0;
    send_a(32'd7, 1'b0);
    send_board_a(32'h0BAD_0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      a_v = 1'b1;
      a_data = 32'd3;
      chk("bp_v", 64'(a_v_o), 64'(1));
      chk("bp_ready", 64'(a_ready), 64'(0));
      chk("bp_frames", 64'(a_frames), 64'(7));
      chk("bp_state", 64'(a_state), 64'(eFULL));
      chk("bp_word0", 64'(a_board[31:0]), 64'h0BAD_0000);
      chk("bp_word31", 64'(a_board[1023:992]), 64'h0BAD_001F);
      tick();
    end
    a_data = 32'd9;
    a_ready_i = 1'b1;
    tick();
    chk("bp_hs_state", 64'(a_state), 64'(eHDR));
    chk("bp_hs_ready", 64'(a_ready), 64'(1));
    chk("bp_hs_frames_held", 64'(a_frames), 64'(7));
    tick();
    a_v = 1'b0;
    chk("bp_next_hdr_state", 64'(a_state), 64'(eDATA));
    chk("bp_next_hdr_frames", 64'(a_frames), 64'(9));

    // packet 4: same board as packet 1 with random v_i gaps
    send_board_a(32'hA5A5_0000, 1'b1);
    chk("p4_frames", 64'(a_frames), 64'(9));
    check_board_a(32'hA5A5_0000);
    tick();

    // packet 5: reset after header plus 10 words
    send_a(32'd3, 1'b0);
    for (int k = 0; k < 10; k++) send_a(32'hDEAD_0000 | 32'(k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 64'(a_v_o), 64'(0));
    chk("mid_rst_ready", 64'(a_ready), 64'(1));
    chk("mid_rst_frames", 64'(a_frames), 64'(0));
    chk("mid_rst_state", 64'(a_state), 64'(eHDR));
    for (int k = 0; k < 32; k++)
      chk($sformatf("mid_rst_word%0d", k), 64'(a_board[k*32 +: 32]), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    send_a(32'd11, 1'b0);
    send_board_a(32'h5A5A_0000, 1'b0);
    chk("p6_frames", 64'(a_frames), 64'(11));
    check_board_a(32'h5A5A_0000);
    tick();

    // instance b: frames 0 passthrough, all-ones board
    send_b(8'd0);
    for (int k = 0; k < 3; k++) send_b(8'hFF);
    chk("b1_v_before_last", 64'(b_v_o), 64'(0));
    send_b(8'hFF);
    chk("b1_v", 64'(b_v_o), 64'(1));
    chk("b1_frames", 64'(b_frames), 64'(0));
    chk("b1_board", 64'(b_board), 64'h1FF_FFFF);
    tick();
    chk("b1_ready_after_hs", 64'(b_ready), 64'(1));

    // instance b: distinct slots, upper 7 bits of last word discarded
    send_b(8'd200);
    send_b(8'h01);
    send_b(8'h80);
    send_b(8'h3C);
    send_b(8'hFE);
    chk("b2_v", 64'(b_v_o), 64'(1));
    chk("b2_frames", 64'(b_frames), 64'(200));
    chk("b2_board", 64'(b_board), 64'h03C_8001);
    tick();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
